// File: rtl/fa_vector_gen.sv
// fa_vector_gen: stimulus source for the 1-bit full adder. Streams either every
// W-bit code in ascending order (BASIC) or a walk that visits every ordered pair
// of distinct codes as consecutive vectors (OPTIONAL) over a valid/ready port.
module fa_vector_gen #(
    parameter int unsigned W = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           mode,
    output logic           vec_valid,
    input  logic           vec_ready,
    output logic [W-1:0]   vec_data,
    output logic [2*W-1:0] vec_idx,
    output logic           vec_last,
    output logic           busy,
    output logic           done
);

    localparam int unsigned N  = 2 ** W;
    localparam int unsigned IW = 2 * W;

    localparam logic [W-1:0] CodeMax   = W'(N - 1);
    localparam logic [W-1:0] CodeMaxM1 = W'(N - 2);
    localparam logic [W-1:0] CodeZero  = '0;

    typedef enum logic [2:0] {
        StIdle,
        StExh,
        StBase,
        StHi,
        StLo,
        StTail,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  i_q, j_q, c_q;
    logic [IW-1:0] idx_q;
    logic          xfer;
    logic          lo_more;

    assign xfer = vec_valid & vec_ready;
    // j-1 >= i+2, evaluated one bit wider so i+3 cannot wrap
    assign lo_more = ({1'b0, j_q} >= ({1'b0, i_q} + (W + 1)'(3)));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; every sequence step waits for a transfer
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = mode ? StBase : StExh;
            end
            StExh: begin
                if (xfer && c_q == CodeMax) state_d = StDone;
            end
            StBase: begin
                if (xfer) state_d = (i_q == CodeMaxM1) ? StTail : StHi;
            end
            StHi: begin
                if (xfer) state_d = StLo;
            end
            StLo: begin
                if (xfer) state_d = lo_more ? StHi : StBase;
            end
            StTail: begin
                if (xfer && c_q == CodeZero) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Sequence counters i, j, c and the running vector index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q   <= '0;
            j_q   <= '0;
            c_q   <= '0;
            idx_q <= '0;
        end else begin
            if (state_q == StIdle && start) begin
                idx_q <= '0;
            end else if (xfer) begin
                idx_q <= idx_q + 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (start) begin
                        c_q <= '0;
                        i_q <= '0;
                    end
                end
                StExh: begin
                    if (xfer && c_q != CodeMax) c_q <= c_q + 1'b1;
                end
                StBase: begin
                    if (xfer) begin
                        if (i_q == CodeMaxM1) c_q <= CodeMax;
                        else                  j_q <= CodeMax;
                    end
                end
                StLo: begin
                    if (xfer) begin
                        if (lo_more) j_q <= j_q - 1'b1;
                        else         i_q <= i_q + 1'b1;
                    end
                end
                StTail: begin
                    if (xfer && c_q != CodeZero) c_q <= c_q - 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from registered state only (no path from vec_ready)
    always_comb begin
        vec_valid = 1'b0;
        vec_data  = '0;
        vec_last  = 1'b0;
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        vec_idx   = idx_q;
        case (state_q)
            StExh: begin
                vec_valid = 1'b1;
                vec_data  = c_q;
                vec_last  = (c_q == CodeMax);
            end
            StBase, StLo: begin
                vec_valid = 1'b1;
                vec_data  = i_q;
            end
            StHi: begin
                vec_valid = 1'b1;
                vec_data  = j_q;
            end
            StTail: begin
                vec_valid = 1'b1;
                vec_data  = c_q;
                vec_last  = (c_q == CodeZero);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/fa_vector_gen.md
# fa_vector_gen

Hardware stimulus generator that sits directly upstream of the 1-bit full adder and drives its `{A,B,CIN}` operand vector. It emits one of two fixed sequences over a valid/ready stream: BASIC (all 2^W codes in ascending order) or OPTIONAL (a transition-coverage walk in which every ordered pair of distinct codes appears as consecutive vectors). It replaces file-based vector generation, so the same sequences run on silicon and in simulation.

## Interface

Parameters:
- `W`, 3, vector width; must be ≥ 2. Derived: `N = 2**W`; `IW = 2*W` (index width).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a sequence; honoured only in IDLE.
- `mode`  in  1  0 = BASIC, 1 = OPTIONAL; sampled only on an accepted `start`.
- `vec_valid`  out  1  `vec_data` holds a vector.
- `vec_ready`  in  1  the full-adder stage accepts the vector.
- `vec_data`  out  W  vector; bit order `{A,B,CIN}`, MSB = A.
- `vec_idx`  out  IW  0-based position of `vec_data` within the sequence.
- `vec_last`  out  1  `vec_data` is the final vector of the sequence.
- `busy`  out  1  a sequence is in progress (any state except IDLE).
- `done`  out  1  one-cycle pulse after the final handshake.

One clock; reset is asynchronous and active-low.

## Operation

- Handshake: a transfer occurs on each rising edge where `vec_valid && vec_ready`. All sequence state advances only on a transfer.
- BASIC: emits 0, 1, …, N-1. Length N (8 for W=3).
- OPTIONAL: length N*(N-1)+1 (57 for W=3).
  - For i = 0 … N-2: emit i; then for j = N-1 down to i+2, emit j, then i.
  - Tail: emit N-1 down to 0.
  - W=3 sequence starts 0,7,0,6,0,5,0,4,0,3,0,2,0,1,7,1,…; ends …,5,6,7,6,5,4,3,2,1,0.
- States: IDLE, EXH, BASE, HI, LO, TAIL, DONE. Registers: `i`, `j`, counter `c`, `vec_idx`.
  - IDLE: on `start`, latch `mode`, clear `vec_idx`. If BASIC, go to EXH with c=0. If OPTIONAL, go to BASE with i=0.
  - EXH: emits c. On transfer: if c = N-1, go to DONE; else c++.
  - BASE: emits i. On transfer: if i = N-2, go to TAIL with c=N-1; else j=N-1 and go to HI.
  - HI: emits j. On transfer, go to LO.
  - LO: emits i. On transfer: if j-1 ≥ i+2, decrement j and go to HI; else increment i and go to BASE.
  - TAIL: emits c. On transfer: if c = 0, go to DONE; else c--.
  - DONE: `done`=1 for one cycle, then IDLE.
- `vec_idx` increments by 1 on every transfer.
- `vec_last`:
  - BASIC: high in EXH when c = N-1.
  - OPTIONAL: high in TAIL when c = 0.
- `vec_data`, `vec_idx` and `vec_last` are registered or decoded from registered state only. They have no combinational path from `vec_ready`.

## Timing

- Reset values: `vec_valid`=0, `vec_data`=0, `vec_idx`=0, `vec_last`=0, `busy`=0, `done`=0. State = IDLE.
- Start latency: `start` high at edge k puts the first vector on the outputs with `vec_valid`=1 and `busy`=1 after edge k.
- Throughput: with `vec_ready` held high, one vector per cycle with no bubbles. BASIC takes N cycles of valid; OPTIONAL takes N*(N-1)+1.
- Backpressure: while `vec_valid && !vec_ready`, `vec_data`, `vec_idx` and `vec_last` stay stable and `vec_valid` stays high.
- Completion: after the transfer of the final vector, `vec_valid`=0 and `done`=1 for one cycle. `busy` drops when the block returns to IDLE on the next edge. A new `start` is accepted on the cycle after `done`.
- A `start` while `busy`=1 is ignored. A `mode` change mid-sequence is ignored.
- `rst_n` low at any time forces all reset values immediately; no partial `done` is issued.
- `vec_valid` is 0 in IDLE and DONE regardless of `vec_ready`.

## Test plan

- BASIC, W=3, `vec_ready`=1: pulse `start`. Required: 8 transfers with data 0..7 and `vec_idx` 0..7; `vec_last` only at idx 7; `done` one cycle after the idx-7 transfer.
- OPTIONAL, W=3, `vec_ready`=1: 57 transfers. First 13 are 0,7,0,6,0,5,0,4,0,3,0,2,0; last 8 are 7..0. A scoreboard confirms all 56 distinct ordered pairs occur as consecutive vectors, each exactly once. `vec_last` only at idx 56.
- Backpressure: OPTIONAL run with `vec_ready` low for 3 cycles at idx 5 (data 5). Required: data=5, idx=5 and `vec_valid`=1 held for 3 cycles, then the sequence continues with idx 6 = data 0. Random-ready run: same 57-vector sequence as the no-stall run.
- Start and mode while busy: during BASIC at idx 3, pulse `start` with `mode`=1. Required: no restart; sequence completes as 0..7 with exactly one `done`.
- Reset mid-run: assert `rst_n`=0 at OPTIONAL idx 20. Required: all outputs at reset values immediately and no `done`. A new `start` restarts at idx 0 with data 0.
- W=2 parameter: OPTIONAL gives 13 vectors: 0,3,0,2,0,1,3,1,2,3,2,1,0.
